// File: rtl/odom_uart_framer_if.sv
// Handshake bundle between the sample producer, the framer and the UART byte transmitter.
// The slave modport is the framer's view; the master modport is the environment's view.
interface odom_uart_framer_if #(
    parameter int DATA_W = 48
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              sample_ready;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_start;

    modport master (
        output sample_valid, sample_data, tx_ready,
        input  sample_ready, tx_data, tx_start
    );

    modport slave (
        input  sample_valid, sample_data, tx_ready,
        output sample_ready, tx_data, tx_start
    );
endinterface

// File: rtl/odom_uart_framer.sv
// Packs one odometry sample into the frame AA 55 SEQ payload CHK and feeds it
// byte by byte to the UART transmitter, pacing on the transmitter's ready line.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for a sample; sample_ready high
// ISSUE      | present byte[byte_idx] with a tx_start pulse once tx_ready is high
// WAIT_BUSY  | wait for tx_ready to drop (byte taken) or for the guard to expire
// WAIT_IDLE  | wait for tx_ready to return, then next byte or finish
// DONE       | frame_done pulse, advance seq
module odom_uart_framer #(
    parameter int N_WORDS = 3,
    parameter int WORD_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    odom_uart_framer_if.slave bus,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        seq,
    output logic [7:0]        drop_cnt
);
    localparam int DATA_W  = N_WORDS * WORD_W;
    localparam int N_BYTES = 4 + DATA_W / 8;
    localparam int IDX_W   = $clog2(N_BYTES);

    localparam logic [IDX_W-1:0] IDX_SYNC0 = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_SYNC1 = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_SEQ   = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_BYTES - 1);

    // The ISSUE cycle already saw tx_ready high, so the guard counts it as the
    // first of the four cycles; WAIT_BUSY therefore waits at most three more.
    localparam logic [1:0] GUARD_LOAD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  shreg;
    logic [IDX_W-1:0]   byte_idx;
    logic [7:0]         chk;
    logic [1:0]         guard_cnt;
    logic [7:0]         byte_cur;
    logic               in_chk;
    logic               in_payload;

    assign busy             = (state != ST_IDLE);
    assign bus.sample_ready = (state == ST_IDLE);
    assign frame_done       = (state == ST_DONE);

    // SEQ and payload bytes feed the checksum; only payload bytes consume the shift register.
    assign in_chk     = (byte_idx >= IDX_SEQ) && (byte_idx != IDX_LAST);
    assign in_payload = (byte_idx >  IDX_SEQ) && (byte_idx != IDX_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.sample_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.tx_ready) state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!bus.tx_ready || guard_cnt == 2'd0) state_nxt = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (bus.tx_ready) state_nxt = (byte_idx == IDX_LAST) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Select the byte for the current frame position.
    always_comb begin
        byte_cur = shreg[DATA_W-1 -: 8];
        if (byte_idx == IDX_SYNC0) begin
            byte_cur = 8'hAA;
        end else if (byte_idx == IDX_SYNC1) begin
            byte_cur = 8'h55;
        end else if (byte_idx == IDX_SEQ) begin
            byte_cur = seq;
        end else if (byte_idx == IDX_LAST) begin
            byte_cur = chk;
        end
    end

    // Frame datapath: sample capture, byte issue, checksum, guard timer, sequence number.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            byte_idx     <= '0;
            chk          <= 8'd0;
            guard_cnt    <= 2'd0;
            seq          <= 8'd0;
            bus.tx_data  <= 8'd0;
            bus.tx_start <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.sample_valid) begin
                        shreg    <= bus.sample_data;
                        byte_idx <= '0;
                        chk      <= 8'd0;
                    end
                end
                ST_ISSUE: begin
                    if (bus.tx_ready) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= byte_cur;
                        guard_cnt    <= GUARD_LOAD;
                        if (in_chk) chk <= chk + byte_cur;
                        if (in_payload) shreg <= {shreg[DATA_W-9:0], 8'h00};
                    end
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_ready && guard_cnt != 2'd0) guard_cnt <= guard_cnt - 2'd1;
                end
                ST_WAIT_IDLE: begin
                    if (bus.tx_ready && byte_idx != IDX_LAST) byte_idx <= byte_idx + IDX_W'(1);
                end
                ST_DONE: begin
                    seq <= seq + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Count samples offered while a frame is in flight (including the DONE cycle); saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (bus.sample_valid && state != ST_IDLE && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_odom_uart_framer.sv
// Bench for odom_uart_framer: a transmitter model paces the byte stream, a
// scoreboard queue holds the expected bytes, and a vector table drives frames.
module tb_odom_uart_framer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq;
    logic [7:0] drop_cnt;

    odom_uart_framer_if #(.DATA_W(48)) bus ();

    odom_uart_framer #(.N_WORDS(3), .WORD_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .seq        (seq),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int         checks      = 0;
    int         failures    = 0;
    int         cyc         = 0;
    int         done_cnt    = 0;
    int         start_cnt   = 0;
    int         accept_cyc  = 0;
    int         last_start  = -1;
    bit         first_pending = 1'b0;
    bit         guard_mode  = 1'b0;
    int         low_left    = 0;
    logic [7:0] exp_seq     = 8'd0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [47:0] sample;
        logic [7:0]  chk;
        int          drops;
        logic [7:0]  drop_exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: ready drops the cycle after tx_start and stays low for 10 cycles,
    // or stays high permanently in guard mode.
    always @(posedge clk) begin
        if (rst || guard_mode) begin
            bus.tx_ready <= 1'b1;
            low_left     <= 0;
        end else if (bus.tx_start) begin
            bus.tx_ready <= 1'b0;
            low_left     <= 10;
        end else if (low_left > 0) begin
            if (low_left == 1) bus.tx_ready <= 1'b1;
            low_left <= low_left - 1;
        end
    end

    // Scoreboard / timing monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (bus.tx_start) begin
                start_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h required=none (t=%0t)", bus.tx_data, $time);
                end else begin
                    check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end
                if (first_pending) begin
                    check("first_latency", 32'(cyc - accept_cyc), 32'd2);
                    first_pending = 1'b0;
                end else if (last_start >= 0) begin
                    check("tx_spacing", 32'(cyc - last_start), guard_mode ? 32'd5 : 32'd13);
                end
                last_start = cyc;
            end
        end
    end

    task automatic push_frame(input logic [47:0] s, input logic [7:0] c);
        logic [47:0] t;
        t = s;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(exp_seq);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(t[47:40]);
            t = t << 8;
        end
        exp_q.push_back(c);
    endtask

    // Waits for sample_ready and presents the sample for one cycle; ends on a negedge.
    task automatic offer_sample(input logic [47:0] s, output bit ok);
        for (int k = 0; k < 300 && !bus.sample_ready; k++) @(negedge clk);
        ok = bus.sample_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL sample_ready_timeout actual=0 required=1 (t=%0t)", $time);
        end else begin
            bus.sample_valid = 1'b1;
            bus.sample_data  = s;
            accept_cyc       = cyc;
            first_pending    = 1'b1;
            @(negedge clk);
            bus.sample_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [47:0] s, input logic [7:0] c, input int drops,
                             input logic [7:0] drop_exp);
        int d0;
        bit ok;
        push_frame(s, c);
        exp_seq = exp_seq + 8'd1;
        d0 = done_cnt;
        offer_sample(s, ok);
        if (ok) begin
            if (drops > 0) begin
                bus.sample_valid = 1'b1;
                bus.sample_data  = ~s;
                repeat (drops) @(negedge clk);
                bus.sample_valid = 1'b0;
            end
            for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
            repeat (2) @(negedge clk);
            check("frame_done_count", 32'(done_cnt - d0), 32'd1);
            check("bytes_left", 32'(exp_q.size()), 32'd0);
            check("seq_after", 32'(seq), 32'(exp_seq));
            check("busy_after", 32'(busy), 32'd0);
            check("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int  s0;
        int  s1;
        bit  ok;

        vecs[0] = '{sample: 48'h0102_0304_0506, chk: 8'h15, drops: 0,   drop_exp: 8'd0};
        vecs[1] = '{sample: 48'hFFFF_FFFF_FFFF, chk: 8'hFB, drops: 5,   drop_exp: 8'd5};
        vecs[2] = '{sample: 48'h0000_0000_0000, chk: 8'h02, drops: 100, drop_exp: 8'd105};
        vecs[3] = '{sample: 48'h1234_5678_9ABC, chk: 8'h6D, drops: 100, drop_exp: 8'd205};
        vecs[4] = '{sample: 48'h0000_0000_00FF, chk: 8'h03, drops: 100, drop_exp: 8'd255};

        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_seq", 32'(seq), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_sample_ready", 32'(bus.sample_ready), 32'd1);

        // Paced frames from the vector table, with drops injected mid-frame.
        guard_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].sample, vecs[i].chk, vecs[i].drops, vecs[i].drop_exp);
        end

        // Constant tx_ready: the guard paces bytes; bring seq up to 255.
        guard_mode = 1'b1;
        for (int i = 0; i < 250; i++) begin
            run_frame(48'h0, exp_seq, 0, 8'd255);
        end
        check("seq_preload", 32'(seq), 32'hFF);
        run_frame(48'h0102_0304_0506, 8'h14, 0, 8'd255);
        check("seq_wrap", 32'(seq), 32'd0);

        // Reset after the fourth byte of a frame.
        guard_mode = 1'b0;
        push_frame(48'h0A0B_0C0D_0E0F, 8'h4B);
        s0 = start_cnt;
        offer_sample(48'h0A0B_0C0D_0E0F, ok);
        for (int k = 0; k < 500 && start_cnt < s0 + 4; k++) @(negedge clk);
        check("abort_point", 32'(start_cnt - s0), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_seq", 32'(seq), 32'd0);
        check("abort_tx_start", 32'(bus.tx_start), 32'd0);
        check("abort_tx_data", 32'(bus.tx_data), 32'd0);
        check("abort_drop_cnt", 32'(drop_cnt), 32'd0);
        check("abort_frame_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        exp_seq       = 8'd0;
        first_pending = 1'b0;
        last_start    = -1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_sample_ready", 32'(bus.sample_ready), 32'd1);
        s1 = start_cnt;
        repeat (30) @(negedge clk);
        check("no_start_after_rst", 32'(start_cnt - s1), 32'd0);
        run_frame(48'h0A0B_0C0D_0E0F, 8'h4B, 0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
